// File: rtl/alu_serial.sv
// Digit-serial 32-bit ALU (add/sub/AND/OR) processing DW bits per clock, LSB digit first.
// Result and ALUFlags are only loaded on completion, so they never show partial digits.
module alu_serial #(
  parameter int DW = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [1:0]  ALUControl,
  output logic        busy,
  output logic        done,
  output logic [31:0] Result,
  output logic [3:0]  ALUFlags,
  output logic [1:0]  dbg_state
);

  localparam int K  = 32 / DW;
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  // Handshake: start is taken on a rising edge only while IDLE or DONE (busy low);
  // busy stays high for exactly K cycles, then done pulses for one cycle with
  // Result/ALUFlags valid. start while busy is ignored; no back-pressure exists.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            accept;
  logic            last;
  logic [CW-1:0]   cnt_q;
  logic [31:0]     a_q, b_q, res_q, res_full;
  logic [1:0]      op_q;
  logic            carry_q;
  logic [4:0]      idx;
  logic [DW-1:0]   a_dig, b_dig, dig;
  logic [DW:0]     sum;
  logic            arith;
  logic            flag_n, flag_z, flag_c, flag_v;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (last) state_d = S_DONE;
      end
      S_DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign dbg_state = state_q;

  // b_q already holds the effective B operand (~b for sub), so the chain is a plain adder.
  assign last  = (cnt_q == CW'(K - 1));
  assign idx   = 5'(int'(cnt_q) * DW);
  assign a_dig = DW'(a_q >> idx);
  assign b_dig = DW'(b_q >> idx);
  assign sum   = {1'b0, a_dig} + {1'b0, b_dig} + {{DW{1'b0}}, carry_q};
  assign arith = ~op_q[1];

  always_comb begin
    dig = sum[DW-1:0];
    case (op_q)
      2'b10:   dig = a_dig & b_dig;
      2'b11:   dig = a_dig | b_dig;
      default: dig = sum[DW-1:0];
    endcase
  end

  // The working register is cleared on accept, so each digit can simply be OR-ed in place.
  assign res_full = res_q | (32'(dig) << idx);
  assign flag_n   = res_full[31];
  assign flag_z   = (res_full == 32'd0);
  assign flag_c   = arith & sum[DW];
  assign flag_v   = arith & (a_q[31] == b_q[31]) & (res_full[31] != a_q[31]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      res_q    <= '0;
      Result   <= '0;
      ALUFlags <= '0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= (ALUControl == 2'b01) ? ~b : b;
      op_q    <= ALUControl;
      cnt_q   <= '0;
      carry_q <= (ALUControl == 2'b01);
      res_q   <= '0;
    end else if (state_q == S_RUN) begin
      res_q   <= res_full;
      carry_q <= sum[DW];
      if (last) begin
        Result   <= res_full;
        ALUFlags <= {flag_n, flag_z, flag_c, flag_v};
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: doc/alu_serial.md
ALU_SERIAL -- requirements
Module: alu_serial

Interface
REQ-001 Parameter DW, default 4, bits processed per cycle; legal values 1, 2, 4, 8, 16, 32; K = 32/DW cycles per operation.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request; sampled on rising edge only while accepting (IDLE or DONE).
REQ-005 a  input  32  operand A; sampled with accepted start.
REQ-006 b  input  32  operand B; sampled with accepted start.
REQ-007 ALUControl  input  2  operation select: 00 add, 01 sub, 10 AND, 11 OR; sampled with accepted start.
REQ-008 busy  output  1  high while an operation is in progress (RUN state).
REQ-009 done  output  1  one-cycle pulse; Result/ALUFlags valid.
REQ-010 Result  output  32  registered result of last completed operation.
REQ-011 ALUFlags  output  4  registered {N,Z,C,V} of last completed operation.

Function
REQ-012 The block SHALL implement states IDLE, RUN, DONE; busy = (state==RUN), done = (state==DONE).
REQ-013 IDLE: start=1 at an edge SHALL latch a, b, ALUControl into working registers, clear digit counter, set carry-in (1 for sub, 0 otherwise), go RUN; start=0 stays IDLE.
REQ-014 RUN: each edge SHALL compute one DW-bit digit, LSB digit first, write it into the result shift register, and propagate carry to the next digit.
REQ-015 Sub SHALL be computed as a + ~b + 1 using the serial carry chain; AND/OR digits SHALL be bitwise and ignore carry.
REQ-016 On the edge computing digit K-1, the block SHALL load Result and ALUFlags and go DONE; done thus asserts on the cycle after the K-th RUN edge (latency K edges from start-accepting edge to done high).
REQ-017 Flags: N = Result[31]; Z = (Result==0); C = carry out of bit 31 for add/sub, 0 for AND/OR; V = signed overflow for add/sub (operand-A and effective-B signs equal, result sign differs), 0 for AND/OR.
REQ-018 DONE: lasts exactly one cycle; start=1 SHALL be accepted (latch, go RUN, done still high that cycle); start=0 goes IDLE.
REQ-019 start while RUN SHALL be ignored; operands and ALUControl changes while RUN SHALL NOT affect the operation in progress.
REQ-020 Result and ALUFlags SHALL hold their values from done until the next completion; they SHALL NOT show partial digits.
REQ-021 Carry from digit K-1 SHALL NOT wrap into digit 0; the digit counter SHALL wrap to 0 only on a new accepted start.
REQ-022 Arithmetic is modulo 2^32; no exceptions or saturation.

Reset
REQ-023 reset=1 SHALL immediately force state IDLE, busy=0, done=0, Result=0, ALUFlags=0, counter=0, carry=0, working registers=0.
REQ-024 reset asserted mid-operation SHALL abort it with no done pulse; first start after deassertion SHALL behave as from power-up.
REQ-025 start is ignored while reset=1.

Verification
REQ-026 Add 0x7FFFFFFF + 0x00000001, DW=4 -> busy for 8 cycles, done 1 cycle, Result 0x80000000, ALUFlags 1001.
REQ-027 Sub 0x00000005 - 0x00000005 -> Result 0x00000000, ALUFlags 0110; add 0xFFFFFFFF + 0x00000001 -> Result 0x00000000, ALUFlags 0110.
REQ-028 AND 0xF0F0F0F0 & 0x0FF00FF0 -> Result 0x00F000F0, ALUFlags 0000; OR 0x80000000 | 0x00000000 -> Result 0x80000000, ALUFlags 1000.
REQ-029 start pulsed at RUN cycle 3 with different operands -> ignored, first result unchanged; start held high in DONE cycle -> second op accepted, busy next cycle, second done exactly 8 edges later, no IDLE gap.
REQ-030 reset asserted at RUN cycle 4 -> busy, done, Result, ALUFlags all 0 at once, no done pulse; subsequent sub 0x00000003 - 0x00000004 -> Result 0xFFFFFFFF, ALUFlags 1000.
REQ-031 Repeat REQ-026 to REQ-028 with DW=1 (done after 32 edges) and DW=32 (done after 1 edge) -> identical Result and ALUFlags.
